seq_digit_adder: RTL and testbench
==================================

Name: seq_digit_adder

Overview:
- Parametrised, multi-cycle digit-serial adder. Computes A+B+cin over WIDTH bits, DIGIT bits per clock.
- Successor to the fixed 4-bit combinational adder. Adds width/digit parametrisation, valid/ready handshakes on input and output, and an FSM-controlled latency.
- Sits between operand producers and result consumers in the datapath, where area matters more than throughput.

Parameters:
- WIDTH, 16: operand and sum width in bits.
- DIGIT, 4: bits added per cycle.
  - WIDTH % DIGIT must be 0 and 1 <= DIGIT <= WIDTH, otherwise it is an elaboration error.
  - NDIG = WIDTH/DIGIT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result; 0 when out_valid=0.
- cout  out  1  carry out; 0 when out_valid=0.
- ovf  out  1  signed overflow; present only with SEQ_DIGIT_ADDER_OVF_EN.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high.
  - While rst=1: state=IDLE, digit counter=0, operand/result/carry registers=0, out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
  - in_valid is ignored while rst=1.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge: capture a, b and cin (cin goes into the carry register), clear the counter, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: add the low DIGIT bits of the A/B shift registers plus the carry register.
  - Shift the DIGIT-bit result into the MSB end of the result register; shift A/B right by DIGIT; update carry.
  - The counter increments each cycle. When counter==NDIG-1, go to HOLD.
- HOLD:
  - out_valid=1, in_ready=0.
  - sum, cout and ovf are stable and unchanged until the handshake.
  - On out_ready=1 at a clock edge: go to IDLE, and out_valid=0 next cycle.
- Latency: operands accepted at edge T produce out_valid=1 after edge T+NDIG.
  - Minimum initiation interval is NDIG+2 cycles (accept, NDIG adds, hand-off, back through IDLE).
- Handshake rules:
  - in_valid while not in IDLE is ignored; operands are not latched.
  - out_ready outside HOLD has no effect.
  - HOLD with out_ready=1 and in_valid=1 returns to IDLE only; the new operands are accepted no earlier than the following edge.
- Arithmetic:
  - Unsigned sum modulo 2^WIDTH.
  - cout = carry out of the MSB digit.
  - Carries propagate across digit boundaries through the carry register (0xFFFF+1 ripples through all NDIG cycles).
- Reset asserted mid-RUN or mid-HOLD:
  - Aborts immediately; no result is emitted.
  - After release, the block is in IDLE and functions normally.
- DIGIT=WIDTH degenerates to a 1-cycle RUN.

Optional Feature:
- Macro: SEQ_DIGIT_ADDER_OVF_EN.
- Defined:
  - Port ovf exists.
  - ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), computed from the captured operand sign bits and the final result.
  - ovf is valid with out_valid and 0 otherwise.
- Undefined: no ovf port and no sign-bit registers; all other behaviour is identical.

Decomposition:
- Package adder_pkg holds:
  - state encoding typedef (IDLE=2'd0, RUN=2'd1, HOLD=2'd2);
  - a function computing counter width, $clog2(NDIG) with a minimum of 1.
- One natural sub-module: digit_add, a combinational DIGIT-bit adder (a_d, b_d, c_in -> s_d, c_out), instantiated once in the RUN datapath.

Test Plan:
- (Default params.) a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0; out_valid rises exactly 4 cycles after the accept edge.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, confirming carry across all digits.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in HOLD -> sum/cout stable, in_ready=0.
  - in_valid with a=0xAAAA is ignored; the next result still matches the original operands.
- Reset during the 2nd RUN cycle:
  - -> out_valid never asserts; all outputs 0; in_ready=1.
  - After release, 0x00FF+0x0F01 -> 0x1000, cout=0.
- With SEQ_DIGIT_ADDER_OVF_EN:
  - 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0.
  - 0x8000+0xFFFF -> sum=0x7FFF, ovf=1, cout=1.
  - 0x0003+0x0004 -> ovf=0.
- Parameter sweep (DIGIT=1 and DIGIT=WIDTH=16), 200 random ops each with random valid/ready gaps -> every result equals the reference sum; latency is 16 and 1 respectively.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared types and helpers for seq_digit_adder.
// Holds the FSM state encoding and the digit-counter width helper.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic int cnt_w(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/digit_add.sv
// digit_add: combinational DIGIT-bit adder with carry in/out.
// One instance forms the whole arithmetic datapath of seq_digit_adder.
module digit_add #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             c_in,
  output logic [DIGIT-1:0] s_d,
  output logic             c_out
);

  assign {c_out, s_d} = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, c_in};

endmodule

// File: rtl/seq_digit_adder.sv
// seq_digit_adder: digit-serial A+B+cin, DIGIT bits per clock, valid/ready I/O.
// Define SEQ_DIGIT_ADDER_OVF_EN to add the signed-overflow output ovf.
module seq_digit_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SEQ_DIGIT_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NDIG = (DIGIT > 0) ? WIDTH / DIGIT : 1;
  localparam int CW   = cnt_w(NDIG);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("seq_digit_adder: DIGIT must divide WIDTH, 1 <= DIGIT <= WIDTH");
  end

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [DIGIT-1:0] w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [WIDTH-1:0] w_sum_nxt;
  logic             w_last;

  digit_add #(
    .DIGIT(DIGIT)
  ) u_digit_add (
    .a_d  (r_a[DIGIT-1:0]),
    .b_d  (r_b[DIGIT-1:0]),
    .c_in (r_carry),
    .s_d  (w_s),
    .c_out(w_c)
  );

  // New digit enters at the MSB end; operands drain from the LSB end.
  if (NDIG == 1) begin : g_one
    assign w_a_nxt   = '0;
    assign w_b_nxt   = '0;
    assign w_sum_nxt = w_s;
  end else begin : g_many
    assign w_a_nxt   = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
    assign w_b_nxt   = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
    assign w_sum_nxt = {w_s, r_sum[WIDTH-1:DIGIT]};
  end

  assign w_last = (r_cnt == CW'(NDIG - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and handshake flags.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: begin
        if (w_last) w_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, then one digit added and shifted per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_sum   <= '0;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a     <= w_a_nxt;
          r_b     <= w_b_nxt;
          r_sum   <= w_sum_nxt;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum  = out_valid ? r_sum : '0;
  assign cout = out_valid & r_carry;

`ifdef SEQ_DIGIT_ADDER_OVF_EN
  logic r_sa;
  logic r_sb;

  // Operand sign bits, kept for the overflow decision at the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sa <= 1'b0;
      r_sb <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_sa <= a[WIDTH-1];
      r_sb <= b[WIDTH-1];
    end
  end

  assign ovf = out_valid & (r_sa == r_sb) & (r_sum[WIDTH-1] != r_sa);
`endif

endmodule

// File: tb/tb_seq_digit_adder.sv
// tb_seq_digit_adder: scoreboard bench for seq_digit_adder at DIGIT=4,1,16.
// Build with SEQ_DIGIT_ADDER_OVF_EN to also cover the ovf output.
module tb_seq_digit_adder;

  logic            clk;
  logic [2:0]      rst;
  logic [2:0]      in_valid;
  logic [2:0]      in_ready;
  logic [2:0]      cin;
  logic [2:0]      out_valid;
  logic [2:0]      out_ready;
  logic [2:0]      cout;
  logic [2:0][15:0] a;
  logic [2:0][15:0] b;
  logic [2:0][15:0] sum;
`ifdef SEQ_DIGIT_ADDER_OVF_EN
  logic [2:0]      ovf;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [17:0] exq [3][$];
  int accq [3][$];
  logic [2:0] seen;
  logic [2:0] done;
  logic [17:0] mon_e;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int DG = (k == 0) ? 4 : ((k == 1) ? 1 : 16);
    seq_digit_adder #(
      .WIDTH(16),
      .DIGIT(DG)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[k]),
      .in_valid (in_valid[k]),
      .in_ready (in_ready[k]),
      .a        (a[k]),
      .b        (b[k]),
      .cin      (cin[k]),
      .out_valid(out_valid[k]),
      .out_ready(out_ready[k]),
      .sum      (sum[k]),
      .cout     (cout[k])
`ifdef SEQ_DIGIT_ADDER_OVF_EN
      ,.ovf     (ovf[k])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic int ndig(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 16 : 1);
  endfunction

  function automatic logic [17:0] ref_add(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic c);
    logic [16:0] s;
    logic v;
    s = {1'b0, x} + {1'b0, y} + {16'd0, c};
    v = (x[15] == y[15]) && (s[15] != x[15]);
    return {v, s};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp_v);
    n_chk++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h",
               tag, $time, got, exp_v);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        exq[k].delete();
        accq[k].delete();
        seen[k] = 1'b0;
      end else begin
        if (out_valid[k]) begin
          if (exq[k].size() == 0) begin
            check($sformatf("sb_underflow[%0d]", k), exq[k].size(), 1);
          end else begin
            if (!seen[k]) begin
              seen[k] = 1'b1;
              check($sformatf("latency[%0d]", k), cyc - accq[k][0], ndig(k));
            end
            if (out_ready[k]) begin
              mon_e = exq[k].pop_front();
              void'(accq[k].pop_front());
              seen[k] = 1'b0;
              check($sformatf("sum[%0d]", k), sum[k], mon_e[15:0]);
              check($sformatf("cout[%0d]", k), cout[k], mon_e[16]);
`ifdef SEQ_DIGIT_ADDER_OVF_EN
              check($sformatf("ovf[%0d]", k), ovf[k], mon_e[17]);
`endif
            end
          end
        end else begin
          check($sformatf("idle_sum[%0d]", k), sum[k], 0);
          check($sformatf("idle_cout[%0d]", k), cout[k], 0);
`ifdef SEQ_DIGIT_ADDER_OVF_EN
          check($sformatf("idle_ovf[%0d]", k), ovf[k], 0);
`endif
        end
        if (in_valid[k] && in_ready[k]) begin
          exq[k].push_back(ref_add(a[k], b[k], cin[k]));
          accq[k].push_back(cyc + 1);
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input int k, input logic [15:0] av,
                      input logic [15:0] bv, input logic c);
    int ok;
    ok = 0;
    in_valid[k] = 1'b1;
    a[k] = av;
    b[k] = bv;
    cin[k] = c;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready[k]) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) check($sformatf("send_timeout[%0d]", k), ok, 1);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exq[k].size() == 0 && in_ready[k]) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) check($sformatf("drain_timeout[%0d]", k), ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic directed();
    int ok;
    logic [15:0] hs;
    logic hc;
    send(0, 16'h1234, 16'h4321, 1'b0);
    drain(0);
    send(0, 16'hFFFF, 16'h0001, 1'b0);
    drain(0);
    send(0, 16'hFFFF, 16'h0000, 1'b1);
    drain(0);
    // Backpressure in HOLD with ignored operands.
    out_ready[0] = 1'b0;
    send(0, 16'h1357, 16'h2468, 1'b0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid[0]) begin
        ok = 1;
        break;
      end
    end
    check("bp_valid", ok, 1);
    hs = sum[0];
    hc = cout[0];
    check("bp_sum", hs, 16'h37BF);
    check("bp_cout", hc, 0);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b1;
    a[0] = 16'hAAAA;
    b[0] = 16'h5555;
    cin[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_sum", sum[0], hs);
      check("bp_hold_cout", cout[0], hc);
      check("bp_in_ready", in_ready[0], 0);
      check("bp_out_valid", out_valid[0], 1);
      @(posedge clk);
      #1;
    end
    out_ready[0] = 1'b1;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (in_ready[0]) begin
        ok = 1;
        break;
      end
    end
    check("bp_reaccept", ok, 1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    drain(0);
    // Reset during the second RUN cycle.
    send(0, 16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(negedge clk);
    check("abort_valid", out_valid[0], 0);
    check("abort_sum", sum[0], 0);
    check("abort_cout", cout[0], 0);
    check("abort_in_ready", in_ready[0], 1);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_out", out_valid[0], 0);
      check("abort_ready", in_ready[0], 1);
    end
    @(posedge clk);
    #1;
    send(0, 16'h00FF, 16'h0F01, 1'b0);
    drain(0);
`ifdef SEQ_DIGIT_ADDER_OVF_EN
    send(0, 16'h7FFF, 16'h0001, 1'b0);
    drain(0);
    send(0, 16'h8000, 16'hFFFF, 1'b0);
    drain(0);
    send(0, 16'h0003, 16'h0004, 1'b0);
    drain(0);
`endif
  endtask

  task automatic sweep(input int k);
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(k, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic toggle(input int k);
    while (!done[k]) begin
      @(posedge clk);
      #1;
      out_ready[k] = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    seen = '0;
    done = '0;
    rst = '1;
    in_valid = '0;
    a = '0;
    b = '0;
    cin = '0;
    out_ready = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready[0], 1);
    check("rst_out_valid", out_valid[0], 0);
    check("rst_sum", sum[0], 0);
    check("rst_cout", cout[0], 0);
    @(posedge clk);
    #1;
    rst = '0;
    fork
      directed();
      begin
        sweep(1);
        done[1] = 1'b1;
      end
      begin
        sweep(2);
        done[2] = 1'b1;
      end
      toggle(1);
      toggle(2);
    join
    out_ready = '1;
    drain(1);
    drain(2);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sb_left[%0d]", k), exq[k].size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
